writeback_regfile: RTL and testbench

// - Writeback stage of the 5-stage pipeline: consumes the MEM/WB latch outputs, selects

---
 rtl/writeback_regfile.sv | 85 ++++++++
 tb/tb_writeback_regfile.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, architectural register file with two read ports,
// retired-instruction counter and last-write record. Define WB_BYPASS_EN for write-through reads.
module writeback_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_read_data,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic              wb_stall,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb_result,
    output logic [ADDR_W-1:0] last_rd,
    output logic              last_rd_valid,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [ADDR_W-1:0] r_last_rd;
    logic              r_last_rd_valid;
    logic [CNT_W-1:0]  r_retired_cnt;

    logic              w_commit;
    logic              w_write_en;
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_rs1_arr;
    logic [DATA_W-1:0] w_rs2_arr;

    assign w_result   = wb_mem_to_reg ? wb_read_data : wb_alu_result;
    assign w_commit   = wb_valid & ~wb_stall;
    assign w_write_en = w_commit & wb_reg_write & (wb_rd != '0);

    // State update; a commit presented during reset is discarded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[ADDR_W'(i)] <= '0;
            end
            r_last_rd       <= '0;
            r_last_rd_valid <= 1'b0;
            r_retired_cnt   <= '0;
        end else begin
            if (w_write_en) begin
                r_regs[wb_rd] <= w_result;
            end
            if (w_commit) begin
                r_retired_cnt   <= r_retired_cnt + CNT_W'(1);
                r_last_rd       <= wb_rd;
                r_last_rd_valid <= w_write_en;
            end else if (!wb_stall) begin
                r_last_rd_valid <= 1'b0;
            end
        end
    end

    // r0 is hardwired to zero on the read side regardless of array contents.
    assign w_rs1_arr = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
    assign w_rs2_arr = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];

`ifdef WB_BYPASS_EN
    // write_en already excludes r0, so the bypass can never expose a nonzero r0.
    assign rs1_data = (w_write_en && (rs1_addr == wb_rd)) ? w_result : w_rs1_arr;
    assign rs2_data = (w_write_en && (rs2_addr == wb_rd)) ? w_result : w_rs2_arr;
`else
    assign rs1_data = w_rs1_arr;
    assign rs2_data = w_rs2_arr;
`endif

    assign wb_result     = w_result;
    assign last_rd       = r_last_rd;
    assign last_rd_valid = r_last_rd_valid;
    assign retired_cnt   = r_retired_cnt;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: stimulus queues expectations tagged with a cycle,
// a negedge monitor compares them. A second instance with CNT_W=4 checks counter wrap.
module tb_writeback_regfile;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam int K_RS1 = 0;
    localparam int K_RS2 = 1;
    localparam int K_RES = 2;
    localparam int K_LRD = 3;
    localparam int K_LRV = 4;
    localparam int K_CNT = 5;
    localparam int K_CNT4 = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wb_valid;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_read_data;
    logic [DATA_W-1:0] wb_alu_result;
    logic              wb_stall;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data, rs2_data, wb_result;
    logic [ADDR_W-1:0] last_rd;
    logic              last_rd_valid;
    logic [31:0]       retired_cnt;

    logic [DATA_W-1:0] b_rs1_data, b_rs2_data, b_wb_result;
    logic [ADDR_W-1:0] b_last_rd;
    logic              b_last_rd_valid;
    logic [3:0]        b_retired_cnt;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    writeback_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_stall(wb_stall), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_result(wb_result),
        .last_rd(last_rd), .last_rd_valid(last_rd_valid), .retired_cnt(retired_cnt)
    );

    writeback_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_stall(wb_stall), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .wb_result(b_wb_result), .last_rd(b_last_rd), .last_rd_valid(b_last_rd_valid),
        .retired_cnt(b_retired_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RS1:   return rs1_data;
            K_RS2:   return rs2_data;
            K_RES:   return wb_result;
            K_LRD:   return 32'(last_rd);
            K_LRV:   return 32'(last_rd_valid);
            K_CNT:   return retired_cnt;
            default: return 32'(b_retired_cnt);
        endcase
    endfunction

    // Monitor: consume every expectation due this cycle, midway between active edges.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.kind);
            total++;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else if (a !== e.val) begin
                bad++;
                $display("FAIL %s got=0x%08h want=0x%08h", e.name, a, e.val);
            end
        end
    end

    task automatic expect_(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        wb_valid = 1'b0;
        wb_stall = 1'b0;
        rs1_addr = a1;
        rs2_addr = a2;
    endtask

    task automatic commit(input logic rw, input logic m2r, input logic [ADDR_W-1:0] rd,
                          input logic [31:0] rdata, input logic [31:0] alu);
        wb_valid      = 1'b1;
        wb_stall      = 1'b0;
        wb_reg_write  = rw;
        wb_mem_to_reg = m2r;
        wb_rd         = rd;
        wb_read_data  = rdata;
        wb_alu_result = alu;
    endtask

    task automatic state(input int cnt, input int lrd, input logic lrv, input string tag);
        expect_(K_CNT, 32'(cnt), {tag, "_cnt"});
        expect_(K_LRD, 32'(lrd), {tag, "_last_rd"});
        expect_(K_LRV, 32'(lrv), {tag, "_last_rd_valid"});
    endtask

    initial begin
        reset_n = 1'b0;
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0; wb_stall = 1'b0;
        wb_rd = '0; wb_read_data = '0; wb_alu_result = '0; rs1_addr = '0; rs2_addr = '0;
        tick(); tick();
        reset_n = 1'b1;

        // Reset state
        idle(5, 0);
        expect_(K_RS1, 32'h0, "reset_r5");
        expect_(K_RS2, 32'h0, "reset_r0");
        state(0, 0, 1'b0, "reset");
        tick();

        // Reset clears a written register; commit during reset is dropped
        idle(5, 0);
        commit(1'b1, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF);
        expect_(K_RES, 32'hDEADBEEF, "res_alu");
        tick();
        idle(5, 0);
        expect_(K_RS1, 32'hDEADBEEF, "r5_written");
        state(1, 5, 1'b1, "after_r5");
        tick();
        reset_n = 1'b0;
        commit(1'b1, 1'b0, 5'd6, 32'h0, 32'h77);
        rs1_addr = 5; rs2_addr = 6;
        expect_(K_RS1, 32'hDEADBEEF, "read_during_reset");
        tick();
        reset_n = 1'b1;
        idle(5, 6);
        expect_(K_RS1, 32'h0, "r5_after_reset");
        expect_(K_RS2, 32'h0, "r6_dropped");
        state(0, 0, 1'b0, "post_reset");
        tick();

        // Result select
        commit(1'b1, 1'b1, 5'd3, 32'h1111, 32'h2222);
        expect_(K_RES, 32'h1111, "res_load");
        tick();
        commit(1'b1, 1'b0, 5'd4, 32'h1111, 32'h2222);
        rs1_addr = 3;
        expect_(K_RES, 32'h2222, "res_alu2");
        expect_(K_RS1, 32'h1111, "r3_load");
        tick();
        idle(4, 3);
        expect_(K_RS1, 32'h2222, "r4_alu");
        expect_(K_RS2, 32'h1111, "r3_port2");
        state(2, 4, 1'b1, "select");
        tick();
        idle(3, 3);
        expect_(K_RS1, 32'h1111, "same_addr_p1");
        expect_(K_RS2, 32'h1111, "same_addr_p2");
        state(2, 4, 1'b0, "idle_clear");
        tick();

        // r0 guard, with a same-cycle read of r0
        commit(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF);
        rs1_addr = 0;
        expect_(K_RS1, 32'h0, "r0_same_cycle");
        tick();
        idle(0, 0);
        expect_(K_RS1, 32'h0, "r0_read");
        state(3, 0, 1'b0, "r0_guard");
        tick();

        // Non-writing instruction still retires
        commit(1'b0, 1'b0, 5'd8, 32'h0, 32'h99);
        tick();
        idle(8, 0);
        expect_(K_RS1, 32'h0, "r8_not_written");
        state(4, 8, 1'b0, "no_write");
        tick();

        // Stall holds everything
        commit(1'b1, 1'b0, 5'd2, 32'h0, 32'h22);
        tick();
        for (int i = 0; i < 3; i++) begin
            commit(1'b1, 1'b0, 5'd7, 32'h0, 32'hA5);
            wb_stall = 1'b1;
            rs1_addr = 7; rs2_addr = 2;
            expect_(K_RS1, 32'h0, "stall_r7");
            expect_(K_RS2, 32'h22, "stall_r2");
            state(5, 2, 1'b1, "stall");
            tick();
        end
        commit(1'b1, 1'b0, 5'd7, 32'h0, 32'hA5);
`ifdef WB_BYPASS_EN
        expect_(K_RS1, 32'hA5, "unstall_r7_now");
`else
        expect_(K_RS1, 32'h0, "unstall_r7_now");
`endif
        tick();
        idle(7, 0);
        expect_(K_RS1, 32'hA5, "unstall_r7");
        state(6, 7, 1'b1, "unstall");
        tick();

        // Same-cycle read of the register being written
        commit(1'b1, 1'b0, 5'd9, 32'h0, 32'h1234);
        rs1_addr = 9; rs2_addr = 9;
`ifdef WB_BYPASS_EN
        expect_(K_RS1, 32'h1234, "bypass_r9_p1");
        expect_(K_RS2, 32'h1234, "bypass_r9_p2");
`else
        expect_(K_RS1, 32'h0, "old_r9_p1");
        expect_(K_RS2, 32'h0, "old_r9_p2");
`endif
        tick();
        idle(9, 0);
        expect_(K_RS1, 32'h1234, "r9_next");
        tick();

        // Counter wrap on the 4-bit instance
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            commit(1'b1, 1'b0, 5'd10, 32'h0, 32'(i + 100));
            tick();
        end
        idle(10, 0);
        expect_(K_CNT4, 32'd1, "wrap_cnt4");
        expect_(K_CNT, 32'd17, "wrap_cnt32");
        expect_(K_RS1, 32'd116, "wrap_r10");
        tick();
        tick();
        tick();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
